lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the data-memory port.
- Accepts one memory op at a time from execute, checks alignment, and drives a req/gnt + rvalid handshake to dmem.
- Aligns and extends load data using the ext_size/ext_unsign controls produced by writeback decode.
- Stalls the pipeline while an access is outstanding and presents a one-cycle writeback pulse for loads.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents a memory op
- ex_is_load  in  1  op is a load
- ex_is_store  in  1  op is a store
- ex_addr  in  ADDR_W  effective byte address
- ex_wdata  in  32  store data (low bytes significant)
- ex_ext_size  in  2  DMEM_EXT_BYTE/HALF/WORD
- ex_ext_unsign  in  1  zero-extend load
- ex_rd  in  5  load destination register
- flush  in  1  kill in-flight op (branch/trap)
- stall  out  1  hold execute stage
- dmem_req  out  1  request valid
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  store data replicated to lanes
- dmem_wstrb  out  4  byte strobes
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- wb_valid  out  1  load result pulse
- wb_rd  out  5  load destination
- wb_data  out  32  extended load data
- st_done  out  1  store completed pulse
- misalign  out  1  misaligned-access exception pulse
- misalign_addr  out  ADDR_W  faulting address

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, wb_valid, st_done, misalign = 0; all address/data/strobe registers = 0.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - When ex_valid & (load|store) & !flush, sample addr, wdata, size, unsign, rd, and the load/store type into registers.
  - Misaligned means HALF with addr[0]=1, or WORD with addr[1:0]!=0. On misalign: misalign=1 and misalign_addr=addr next cycle, no dmem request, stay IDLE.
  - Otherwise go to REQ. dmem_req=1 from the next cycle.
  - If both load and store are set, the op is treated as a store.
- stall: 1 in IDLE when an aligned op is being accepted (combinational); 1 in REQ and WAIT; 1 in DRAIN only if ex_valid (a new op cannot be accepted there); 0 otherwise.
- REQ: hold dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_wstrb stable until dmem_gnt. On gnt:
  - store: st_done pulse next cycle, go to IDLE.
  - load: go to WAIT.
- dmem_req drops the cycle after gnt. Minimum store latency is accept + 2 cycles.
- Store lanes:
  - BYTE: wdata = {4{b}}, wstrb = 1 << addr[1:0].
  - HALF: wdata = {2{h}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - WORD: wstrb = 4'b1111.
- Load strobes: dmem_we=0 and wstrb=0.
- WAIT: dmem_rvalid is honoured only in WAIT. On rvalid, the next cycle gives wb_valid=1, wb_rd, and wb_data = rdata shifted right by 8*addr[1:0] (HALF uses addr[1]), then sign- or zero-extended; state goes to IDLE.
- wb_valid, st_done and misalign are single-cycle pulses.
- Flush:
  - In REQ before gnt: drop dmem_req next cycle, go to IDLE, no pulse.
  - In REQ coinciding with gnt: a store still completes (st_done pulses); a load goes to DRAIN.
  - In WAIT: go to DRAIN.
  - DRAIN waits for rvalid, discards it with no wb_valid, then goes to IDLE.
  - Flush in IDLE blocks acceptance that cycle.
- Asynchronous reset mid-operation returns to IDLE immediately. The memory side must tolerate the abandoned request.
- Only one op is outstanding at a time; there is no buffering.

Decomposition:
- DMEM_EXT_* size codes and FNC_* codes stay in CtrlCode.vh / OpCode.vh. Add LSU_ST_* state encodings (2 bits) to CtrlCode.vh.
- One combinational sub-module, lsu_ext, holds load lane-select and extension (rdata, offset, size, unsign -> data). It is reused by any future cache path.
- Store lane/strobe generation stays inline.

Test Plan:
- LB at addr 0x103, rdata=0x80FF_1234, gnt same cycle as req, rvalid 2 cycles later -> wb_data=0xFFFF_FF80, one wb_valid pulse, correct wb_rd, stall high from accept until the pulse.
- LHU at 0x102, rdata=0x8001_0000 -> wb_data=0x0000_8001. LW at 0x100 -> wb_data=rdata.
- SB 0xAB at 0x101 with gnt held low 3 cycles -> req, addr=0x100, wstrb=0010 and wdata=0xABABABAB held stable for 4 cycles; st_done pulses once after gnt.
- LW at 0x102 -> misalign=1 with misalign_addr=0x102, dmem_req never asserts. SH at 0x101 -> same exception.
- Load with flush during WAIT, rvalid 3 cycles later -> no wb_valid, state IDLE after rvalid, next LW accepted and completes normally.
- rst_n low while in WAIT -> dmem_req, stall and wb_valid all 0 immediately; a late rvalid after reset is ignored.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: access size codes, sequencer states
// and the alignment rule used at op acceptance.
package lsu_ctrl_pkg;

    localparam logic [1:0] DMEM_EXT_BYTE = 2'd0;
    localparam logic [1:0] DMEM_EXT_HALF = 2'd1;
    localparam logic [1:0] DMEM_EXT_WORD = 2'd2;

    localparam logic [1:0] LSU_ST_IDLE  = 2'd0;
    localparam logic [1:0] LSU_ST_REQ   = 2'd1;
    localparam logic [1:0] LSU_ST_WAIT  = 2'd2;
    localparam logic [1:0] LSU_ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = LSU_ST_IDLE,
        StReq   = LSU_ST_REQ,
        StWait  = LSU_ST_WAIT,
        StDrain = LSU_ST_DRAIN
    } lsu_state_e;

    // Unknown size codes are treated as word accesses.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            DMEM_EXT_BYTE: mis = 1'b0;
            DMEM_EXT_HALF: mis = off[0];
            default:       mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load lane select and sign/zero extension of a 32-bit read word.
module lsu_ext
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic [31:0] data
);

    logic [4:0]  sh;
    logic [31:0] shifted;

    always_comb begin
        sh = 5'd0;
        case (size)
            DMEM_EXT_BYTE: sh = {offset, 3'b000};
            DMEM_EXT_HALF: sh = {offset[1], 4'b0000};
            default:       sh = 5'd0;
        endcase
        shifted = rdata >> sh;
    end

    always_comb begin
        data = shifted;
        case (size)
            DMEM_EXT_BYTE: data = unsign ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            DMEM_EXT_HALF: data = unsign ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default:       data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one op at a time from execute to the dmem req/gnt/rvalid port,
// with alignment checking, store lane steering and extended load writeback.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [1:0]        ex_ext_size,
    input  logic              ex_ext_unsign,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              st_done,
    output logic              misalign,
    output logic [ADDR_W-1:0] misalign_addr
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsign_q, unsign_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              st_done_q, st_done_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_wstrb;
    logic [DATA_W-1:0] ld_data;
    logic              take_op;

    assign take_op = ex_valid && (ex_is_load || ex_is_store) && !flush;

    // Store data is replicated across lanes so memory only needs the strobes.
    always_comb begin
        st_wdata = ex_wdata;
        st_wstrb = 4'b1111;
        case (ex_ext_size)
            DMEM_EXT_BYTE: begin
                st_wdata = {4{ex_wdata[7:0]}};
                st_wstrb = 4'b0001 << ex_addr[1:0];
            end
            DMEM_EXT_HALF: begin
                st_wdata = {2{ex_wdata[15:0]}};
                st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = ex_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    lsu_ext u_ext (
        .rdata  (dmem_rdata),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .unsign (unsign_q),
        .data   (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        we_d            = we_q;
        size_d          = size_q;
        unsign_d        = unsign_q;
        rd_d            = rd_q;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        st_done_d       = 1'b0;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        stall           = 1'b0;

        case (state_q)
            StIdle: begin
                if (take_op) begin
                    if (lsu_misaligned(ex_ext_size, ex_addr[1:0])) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = ex_addr;
                    end else begin
                        stall    = 1'b1;
                        state_d  = StReq;
                        addr_d   = ex_addr;
                        size_d   = ex_ext_size;
                        unsign_d = ex_ext_unsign;
                        rd_d     = ex_rd;
                        // A op flagged as both load and store is a store.
                        we_d     = ex_is_store;
                        wdata_d  = st_wdata;
                        wstrb_d  = ex_is_store ? st_wstrb : 4'b0000;
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (dmem_gnt) begin
                    if (we_q) begin
                        st_done_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        state_d = flush ? StDrain : StWait;
                    end
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    // The response has arrived; a concurrent flush only suppresses writeback.
                    wb_valid_d = !flush;
                    wb_rd_d    = flush ? wb_rd_q : rd_q;
                    wb_data_d  = flush ? wb_data_q : ld_data;
                    state_d    = StIdle;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                stall = ex_valid;
                if (dmem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            we_q            <= 1'b0;
            size_q          <= '0;
            unsign_q        <= 1'b0;
            rd_q            <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            st_done_q       <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            we_q            <= we_d;
            size_q          <= size_d;
            unsign_q        <= unsign_d;
            rd_q            <= rd_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            st_done_q       <= st_done_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign dmem_req      = (state_q == StReq);
    assign dmem_we       = dmem_req && we_q;
    assign dmem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata    = wdata_q;
    assign dmem_wstrb    = wstrb_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign st_done       = st_done_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized loads/stores
// checked against a byte-lane reference model.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_ext_size;
    logic        ex_ext_unsign;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done, misalign;
    logic [31:0] misalign_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .ex_ext_size   (ex_ext_size),
        .ex_ext_unsign (ex_ext_unsign),
        .ex_rd         (ex_rd),
        .flush         (flush),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .st_done       (st_done),
        .misalign      (misalign),
        .misalign_addr (misalign_addr)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == DMEM_EXT_BYTE) return 1;
        if (sz == DMEM_EXT_HALF) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] sz, input logic uns);
        int nb = nbytes(sz);
        int off = (nb == 4) ? 0 : int'(addr % 4);
        logic [63:0] v, m;
        v = {32'h0, rdata} >> (8 * off);
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (!uns && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [1:0] sz);
        int nb = nbytes(sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [31:0] addr, input logic [1:0] sz);
        int nb = nbytes(sz);
        int off = int'(addr % 4);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nb);
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic present(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                           input logic [31:0] wd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_addr = addr;
        ex_ext_size = sz; ex_ext_unsign = uns; ex_rd = rd; ex_wdata = wd;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                            input logic [4:0] rd, input logic [31:0] rdata, input int gnt_dly,
                            input int rv_dly, input string nm);
        logic [31:0] exp_d;
        exp_d = model_load(rdata, addr, sz, uns);
        present(1'b1, 1'b0, addr, sz, uns, rd, $urandom);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL %s accept_stall: got %b want 1", nm, stall);
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk);
            idle_ex();
            dmem_gnt = (k == gnt_dly);
            #1;
            n_tests++;
            if ({dmem_req, dmem_we, dmem_wstrb, stall, wb_valid} !== 8'b1_0_0000_1_0) begin
                n_fail++;
                $display("FAIL %s req_phase: req/we/strb/stall/wbv=%b want 10000010", nm,
                         {dmem_req, dmem_we, dmem_wstrb, stall, wb_valid});
            end
            n_tests++;
            if (dmem_addr !== {addr[31:2], 2'b00}) begin
                n_fail++; $display("FAIL %s req_addr: got %h want %h", nm, dmem_addr,
                                   {addr[31:2], 2'b00});
            end
        end
        for (int j = 0; j < rv_dly; j++) begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            #1;
            n_tests++;
            if ({dmem_req, stall, wb_valid} !== 3'b010) begin
                n_fail++; $display("FAIL %s wait_phase: req/stall/wbv=%b want 010", nm,
                                   {dmem_req, stall, wb_valid});
            end
        end
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        #1;
        n_tests++;
        if ({wb_valid, stall, dmem_req} !== 3'b100 || wb_rd !== rd || wb_data !== exp_d) begin
            n_fail++;
            $display("FAIL %s writeback: wbv/stall/req=%b rd=%0d data=%h want 100 rd=%0d data=%h",
                     nm, {wb_valid, stall, dmem_req}, wb_rd, wb_data, rd, exp_d);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s wb_pulse: wb_valid still %b", nm, wb_valid);
        end
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd,
                             input int gnt_dly, input logic also_ld, input string nm);
        logic [31:0] exp_w;
        logic [3:0]  exp_s;
        exp_w = model_wdata(wd, sz);
        exp_s = model_wstrb(addr, sz);
        present(also_ld, 1'b1, addr, sz, 1'b0, 5'd0, wd);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL %s accept_stall: got %b want 1", nm, stall);
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk);
            idle_ex();
            dmem_gnt = (k == gnt_dly);
            #1;
            n_tests++;
            if ({dmem_req, dmem_we, dmem_wstrb, stall, st_done} !== {2'b11, exp_s, 2'b10}) begin
                n_fail++;
                $display("FAIL %s req_phase: req/we/strb/stall/done=%b want %b", nm,
                         {dmem_req, dmem_we, dmem_wstrb, stall, st_done}, {2'b11, exp_s, 2'b10});
            end
            n_tests++;
            if (dmem_addr !== {addr[31:2], 2'b00} || dmem_wdata !== exp_w) begin
                n_fail++; $display("FAIL %s req_bus: addr=%h wdata=%h want %h %h", nm, dmem_addr,
                                   dmem_wdata, {addr[31:2], 2'b00}, exp_w);
            end
        end
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        n_tests++;
        if ({st_done, dmem_req, stall} !== 3'b100) begin
            n_fail++; $display("FAIL %s st_done: done/req/stall=%b want 100", nm,
                               {st_done, dmem_req, stall});
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (st_done !== 1'b0) begin
            n_fail++; $display("FAIL %s st_pulse: st_done still %b", nm, st_done);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({dmem_req, dmem_we, wb_valid, st_done, misalign, stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: req/we/wbv/done/mis/stall=%b want 000000",
                               {dmem_req, dmem_we, wb_valid, st_done, misalign, stall});
        end
        n_tests++;
        if ({dmem_addr, dmem_wdata, dmem_wstrb, wb_data, misalign_addr} !== 132'h0) begin
            n_fail++; $display("FAIL reset_regs: addr=%h wdata=%h strb=%b wbd=%h maddr=%h want 0",
                               dmem_addr, dmem_wdata, dmem_wstrb, wb_data, misalign_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        run_load(32'h103, DMEM_EXT_BYTE, 1'b0, 5'd7,  32'h80FF_1234, 0, 2, "lb_sign");
        run_load(32'h102, DMEM_EXT_HALF, 1'b1, 5'd12, 32'h8001_0000, 1, 0, "lhu");
        run_load(32'h100, DMEM_EXT_WORD, 1'b0, 5'd31, 32'hDEAD_BEEF, 2, 1, "lw");
        run_load(32'h102, DMEM_EXT_HALF, 1'b0, 5'd3,  32'h8001_0000, 0, 0, "lh_sign");
        run_load(32'h101, DMEM_EXT_BYTE, 1'b1, 5'd4,  32'h0000_F200, 0, 3, "lbu");
    endtask

    task automatic test_stores();
        run_store(32'h101, DMEM_EXT_BYTE, 32'h0000_00AB, 3, 1'b0, "sb_gnt_late");
        run_store(32'h202, DMEM_EXT_HALF, 32'h1234_5678, 0, 1'b0, "sh_hi");
        run_store(32'h200, DMEM_EXT_WORD, 32'hCAFE_F00D, 1, 1'b0, "sw");
        run_store(32'h204, DMEM_EXT_BYTE, 32'h0000_0011, 0, 1'b1, "ld_st_is_store");
    endtask

    task automatic test_misalign();
        logic [31:0] addrs [2];
        logic [1:0]  szs   [2];
        logic        lds   [2];
        addrs = '{32'h102, 32'h101};
        szs   = '{DMEM_EXT_WORD, DMEM_EXT_HALF};
        lds   = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            present(lds[i], !lds[i], addrs[i], szs[i], 1'b0, 5'd1, 32'h5555_5555);
            #1;
            n_tests++;
            if ({stall, dmem_req} !== 2'b00) begin
                n_fail++; $display("FAIL misalign%0d_accept: stall/req=%b want 00", i,
                                   {stall, dmem_req});
            end
            @(negedge clk);
            idle_ex();
            #1;
            n_tests++;
            if ({misalign, dmem_req} !== 2'b10 || misalign_addr !== addrs[i]) begin
                n_fail++; $display("FAIL misalign%0d_pulse: mis/req=%b addr=%h want 10 %h", i,
                                   {misalign, dmem_req}, misalign_addr, addrs[i]);
            end
            @(negedge clk);
            #1;
            n_tests++;
            if ({misalign, dmem_req, stall} !== 3'b000) begin
                n_fail++; $display("FAIL misalign%0d_after: mis/req/stall=%b want 000", i,
                                   {misalign, dmem_req, stall});
            end
        end
    endtask

    task automatic test_flush_wait();
        present(1'b1, 1'b0, 32'h300, DMEM_EXT_WORD, 1'b0, 5'd9, 32'h0);
        @(negedge clk);
        idle_ex(); dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL drain_stall_ev: got %b want 1", stall);
        end
        ex_valid = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL drain_stall_idle: got %b want 0", stall);
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({wb_valid, dmem_req} !== 2'b00) begin
                n_fail++; $display("FAIL drain_wait: wbv/req=%b want 00", {wb_valid, dmem_req});
            end
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({wb_valid, stall} !== 2'b00) begin
            n_fail++; $display("FAIL drain_discard: wbv/stall=%b want 00", {wb_valid, stall});
        end
        @(negedge clk);
        run_load(32'h304, DMEM_EXT_WORD, 1'b0, 5'd10, 32'h7777_8888, 0, 1, "after_drain");
    endtask

    task automatic test_flush_req();
        // flush before grant: request withdrawn, no completion
        present(1'b0, 1'b1, 32'h400, DMEM_EXT_WORD, 1'b0, 5'd0, 32'h1);
        @(negedge clk);
        idle_ex(); flush = 1'b1;
        #1;
        n_tests++;
        if (dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL flush_req_pre: req=%b want 1", dmem_req);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_tests++;
        if ({dmem_req, st_done, stall} !== 3'b000) begin
            n_fail++; $display("FAIL flush_req_drop: req/done/stall=%b want 000",
                               {dmem_req, st_done, stall});
        end
        // flush with grant: store still completes
        @(negedge clk);
        present(1'b0, 1'b1, 32'h404, DMEM_EXT_WORD, 1'b0, 5'd0, 32'h2);
        @(negedge clk);
        idle_ex(); flush = 1'b1; dmem_gnt = 1'b1;
        @(negedge clk);
        flush = 1'b0; dmem_gnt = 1'b0;
        #1;
        n_tests++;
        if ({st_done, dmem_req} !== 2'b10) begin
            n_fail++; $display("FAIL flush_gnt_store: done/req=%b want 10", {st_done, dmem_req});
        end
        // flush with grant: load drained, never written back
        @(negedge clk);
        present(1'b1, 1'b0, 32'h408, DMEM_EXT_WORD, 1'b0, 5'd5, 32'h0);
        @(negedge clk);
        idle_ex(); flush = 1'b1; dmem_gnt = 1'b1;
        @(negedge clk);
        flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({wb_valid, stall, dmem_req} !== 3'b000) begin
            n_fail++; $display("FAIL flush_gnt_load: wbv/stall/req=%b want 000",
                               {wb_valid, stall, dmem_req});
        end
        // flush in idle blocks acceptance
        @(negedge clk);
        present(1'b1, 1'b0, 32'h40C, DMEM_EXT_WORD, 1'b0, 5'd5, 32'h0);
        flush = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_stall: got %b want 0", stall);
        end
        @(negedge clk);
        idle_ex(); flush = 1'b0;
        #1;
        n_tests++;
        if (dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_req: got %b want 0", dmem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        // reset while waiting for read data
        present(1'b1, 1'b0, 32'h500, DMEM_EXT_WORD, 1'b0, 5'd6, 32'h0);
        @(negedge clk);
        idle_ex(); dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dmem_req, stall, wb_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rst_wait: req/stall/wbv=%b want 000",
                               {dmem_req, stall, wb_valid});
        end
        @(negedge clk);
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD_0123;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        n_tests++;
        if ({wb_valid, stall} !== 2'b00) begin
            n_fail++; $display("FAIL rst_late_rvalid: wbv/stall=%b want 00", {wb_valid, stall});
        end
        // reset while a request is pending
        @(negedge clk);
        present(1'b0, 1'b1, 32'h504, DMEM_EXT_WORD, 1'b0, 5'd0, 32'h9);
        @(negedge clk);
        idle_ex();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dmem_req, dmem_we, stall} !== 3'b000) begin
            n_fail++; $display("FAIL rst_req: req/we/stall=%b want 000", {dmem_req, dmem_we, stall});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic [31:0] addr;
            sz   = 2'($urandom_range(0, 2));
            addr = $urandom & ~(32'(nbytes(sz)) - 32'd1);
            if ($urandom_range(0, 1) == 0)
                run_load(addr, sz, 1'($urandom), 5'($urandom), $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3), "rnd_ld");
            else
                run_store(addr, sz, $urandom, $urandom_range(0, 3), 1'b0, "rnd_st");
            @(negedge clk);
        end
    endtask

    initial begin
        idle_ex();
        ex_addr = '0; ex_wdata = '0; ex_ext_size = '0; ex_ext_unsign = 1'b0; ex_rd = '0;
        flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        test_reset();
        @(negedge clk);
        test_loads();
        test_stores();
        test_misalign();
        test_flush_wait();
        test_flush_req();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
